// File: rtl/program_loader_if.sv
// Byte-stream input and memory write-port bundle for the program loader.
// The slave side is the loader; the master side is the stream source and memory.
interface program_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [DATA_W-1:0] mem_dado;
  logic [ADDR_W-1:0] mem_endereco;
  logic              mem_write;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  mem_dado,
    input  mem_endereco,
    input  mem_write
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output mem_dado,
    output mem_endereco,
    output mem_write
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader: receives a length-prefixed byte stream, writes
// big-endian 32-bit words to memory and checks a trailing XOR checksum.
// The processor is held in reset until a verified image is in place.
module program_loader #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 128,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  program_loader_if.slave    bus,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic               cpu_hold
);

  localparam logic [15:0]       MAX_LEN = 16'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_COLLECT = 3'd3,
    ST_WRITE   = 3'd4,
    ST_CHK     = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

  state_t            state_r;
  state_t            state_s;

  logic [7:0]        len_hi_r;
  logic [15:0]       words_left_r;
  logic [1:0]        byte_idx_r;
  logic [7:0]        chk_r;
  logic [DATA_W-1:0] word_r;
  logic [ADDR_W-1:0] addr_r;

  logic              byte_ready_r;
  logic              mem_write_r;
  logic              busy_r;
  logic              done_r;
  logic              error_r;
  logic              cpu_hold_r;

  logic              transfer_s;
  logic [15:0]       len_s;

  assign transfer_s = bus.byte_valid & byte_ready_r;
  assign len_s      = {len_hi_r, bus.byte_in};

  assign bus.byte_ready   = byte_ready_r;
  assign bus.mem_write    = mem_write_r;
  assign bus.mem_dado     = word_r;
  assign bus.mem_endereco = addr_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign error            = error_r;
  assign cpu_hold         = cpu_hold_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; start is only honoured outside a session.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_s = ST_LEN_HI;
        else       state_s = state_r;
      end
      ST_LEN_HI: begin
        if (transfer_s) state_s = ST_LEN_LO;
        else            state_s = ST_LEN_HI;
      end
      ST_LEN_LO: begin
        if (transfer_s) begin
          if (len_s == 16'd0)        state_s = ST_CHK;
          else if (len_s > MAX_LEN)  state_s = ST_ERR;
          else                       state_s = ST_COLLECT;
        end else begin
          state_s = ST_LEN_LO;
        end
      end
      ST_COLLECT: begin
        if (transfer_s && (byte_idx_r == 2'd3)) state_s = ST_WRITE;
        else                                    state_s = ST_COLLECT;
      end
      ST_WRITE: begin
        if (words_left_r == 16'd1) state_s = ST_CHK;
        else                       state_s = ST_COLLECT;
      end
      ST_CHK: begin
        if (transfer_s) begin
          if (bus.byte_in == chk_r) state_s = ST_DONE;
          else                      state_s = ST_ERR;
        end else begin
          state_s = ST_CHK;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Outputs registered from the next state so they line up with state_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_ready_r <= 1'b0;
      mem_write_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      cpu_hold_r   <= 1'b1;
    end else begin
      byte_ready_r <= (state_s inside {ST_LEN_HI, ST_LEN_LO, ST_COLLECT, ST_CHK});
      mem_write_r  <= (state_s == ST_WRITE);
      busy_r       <= (state_s inside {ST_LEN_HI, ST_LEN_LO, ST_COLLECT, ST_WRITE, ST_CHK});
      done_r       <= (state_s == ST_DONE);
      error_r      <= (state_s == ST_ERR);
      cpu_hold_r   <= (state_s != ST_DONE);
    end
  end

  // Datapath: length capture, word assembly, checksum, address and word count.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi_r     <= 8'd0;
      words_left_r <= 16'd0;
      byte_idx_r   <= 2'd0;
      chk_r        <= 8'd0;
      word_r       <= '0;
      addr_r       <= BASE;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            byte_idx_r   <= 2'd0;
            chk_r        <= 8'd0;
            words_left_r <= 16'd0;
            addr_r       <= BASE;
          end
        end
        ST_LEN_HI: begin
          if (transfer_s) len_hi_r <= bus.byte_in;
        end
        ST_LEN_LO: begin
          if (transfer_s) words_left_r <= len_s;
        end
        ST_COLLECT: begin
          if (transfer_s) begin
            word_r     <= {word_r[DATA_W-9:0], bus.byte_in};
            chk_r      <= chk_r ^ bus.byte_in;
            byte_idx_r <= byte_idx_r + 2'd1;
          end
        end
        ST_WRITE: begin
          addr_r       <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          words_left_r <= words_left_r - 16'd1;
        end
        default: begin
          len_hi_r <= len_hi_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, error, cpu_hold;

  int errors = 0;
  int checks = 0;

  program_loader_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  program_loader #(.ADDR_W(10), .DATA_W(32), .MAX_WORDS(128), .BASE_ADDR(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  // Write log captured mid-cycle
  logic [31:0] wr_data [0:15];
  logic [9:0]  wr_addr [0:15];
  int          wr_n = 0;
  int          rdy_viol = 0;
  int          dbl_write = 0;
  logic        prev_write = 1'b0;

  always @(negedge clk) begin
    if (bus.mem_write === 1'b1) begin
      if (wr_n < 16) begin
        wr_data[wr_n] = bus.mem_dado;
        wr_addr[wr_n] = bus.mem_endereco;
      end
      wr_n = wr_n + 1;
      if (bus.byte_ready !== 1'b0) rdy_viol = rdy_viol + 1;
      if (prev_write) dbl_write = dbl_write + 1;
    end
    prev_write = (bus.mem_write === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc = 1'b0;
    int n = 0;
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    while (!acc && n < 50) begin
      acc = (bus.byte_ready === 1'b1);
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    bus.byte_valid = 1'b0;
    if (!acc) begin
      checks = checks + 1;
      errors = errors + 1;
      $error("FAIL byte_timeout: observed no accept expected accept of %0h", b);
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    send_byte(w[31:24], gap);
    send_byte(w[23:16], gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.byte_ready, 1'b0);
    chk({tag, "_write"}, bus.mem_write, 1'b0);
    chk({tag, "_dado"}, bus.mem_dado, 32'h0);
    chk({tag, "_addr"}, bus.mem_endereco, 10'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
    chk({tag, "_hold"}, cpu_hold, 1'b1);
  endtask

  int base;

  initial begin
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst0");
    rst = 1'b0;
    @(negedge clk);

    // byte_valid in IDLE is ignored
    bus.byte_valid = 1'b1;
    bus.byte_in = 8'h5A;
    repeat (3) @(negedge clk);
    chk("idle_ready", bus.byte_ready, 1'b0);
    chk("idle_busy", busy, 1'b0);
    bus.byte_valid = 1'b0;

    // Test 1: single word DEADBEEF, checksum 22
    base = wr_n;
    pulse_start();
    chk("t1_busy", busy, 1'b1);
    chk("t1_ready", bus.byte_ready, 1'b1);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'hDEADBEEF, 0);
    chk("t1_k1_write", bus.mem_write, 1'b1);
    chk("t1_k1_ready", bus.byte_ready, 1'b0);
    chk("t1_k1_dado", bus.mem_dado, 32'hDEADBEEF);
    chk("t1_k1_addr", bus.mem_endereco, 10'd0);
    @(negedge clk);
    chk("t1_k2_write", bus.mem_write, 1'b0);
    chk("t1_k2_ready", bus.byte_ready, 1'b1);
    send_byte(8'h22, 0);
    chk("t1_nwr", wr_n - base, 1);
    chk("t1_wdata", wr_data[base], 32'hDEADBEEF);
    chk("t1_waddr", wr_addr[base], 10'd0);
    chk("t1_done", done, 1'b1);
    chk("t1_hold", cpu_hold, 1'b0);
    chk("t1_error", error, 1'b0);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_ready_end", bus.byte_ready, 1'b0);

    // Test 2: N=3, checksum D6, with a start pulse mid-session that must be ignored
    base = wr_n;
    pulse_start();
    chk("t2_hold", cpu_hold, 1'b1);
    chk("t2_done_clr", done, 1'b0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    pulse_start();
    send_word(32'h04001FCD, 0);
    send_word(32'h5400001C, 0);
    send_word(32'h48000000, 0);
    send_byte(8'hD6, 0);
    chk("t2_nwr", wr_n - base, 3);
    chk("t2_wd0", wr_data[base], 32'h04001FCD);
    chk("t2_wa0", wr_addr[base], 10'd0);
    chk("t2_wd1", wr_data[base+1], 32'h5400001C);
    chk("t2_wa1", wr_addr[base+1], 10'd1);
    chk("t2_wd2", wr_data[base+2], 32'h48000000);
    chk("t2_wa2", wr_addr[base+2], 10'd2);
    chk("t2_done", done, 1'b1);
    chk("t2_error", error, 1'b0);

    // Test 3: length 129 exceeds memory depth
    base = wr_n;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h81, 0);
    chk("t3_error", error, 1'b1);
    chk("t3_hold", cpu_hold, 1'b1);
    chk("t3_ready", bus.byte_ready, 1'b0);
    chk("t3_done", done, 1'b0);
    bus.byte_in = 8'h12;
    bus.byte_valid = 1'b1;
    repeat (4) @(negedge clk);
    bus.byte_valid = 1'b0;
    chk("t3_ready_late", bus.byte_ready, 1'b0);
    chk("t3_error_sticky", error, 1'b1);
    chk("t3_nwr", wr_n - base, 0);

    // Test 4: bad checksum (00 instead of 44)
    base = wr_n;
    pulse_start();
    chk("t4_error_clr", error, 1'b0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_word(32'h11223344, 0);
    send_byte(8'h00, 0);
    chk("t4_nwr", wr_n - base, 1);
    chk("t4_wdata", wr_data[base], 32'h11223344);
    chk("t4_error", error, 1'b1);
    chk("t4_done", done, 1'b0);
    chk("t4_hold", cpu_hold, 1'b1);

    // Test 5: N=2 with byte_valid toggling every cycle, checksum 09
    base = wr_n;
    pulse_start();
    send_byte(8'h00, 1);
    send_byte(8'h02, 1);
    send_word(32'hA5A50001, 1);
    send_word(32'h12345678, 1);
    send_byte(8'h09, 1);
    chk("t5_nwr", wr_n - base, 2);
    chk("t5_wd0", wr_data[base], 32'hA5A50001);
    chk("t5_wa0", wr_addr[base], 10'd0);
    chk("t5_wd1", wr_data[base+1], 32'h12345678);
    chk("t5_wa1", wr_addr[base+1], 10'd1);
    chk("t5_done", done, 1'b1);
    chk("t5_hold", cpu_hold, 1'b0);

    // Test 6: reset after 2nd data byte, then a clean reload
    base = wr_n;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("t6_rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_nwr_abort", wr_n - base, 0);
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(32'hCAFEBABE, 0);
    send_word(32'h00000001, 0);
    send_byte(8'h31, 0);
    chk("t6_nwr", wr_n - base, 2);
    chk("t6_wd0", wr_data[base], 32'hCAFEBABE);
    chk("t6_wa0", wr_addr[base], 10'd0);
    chk("t6_wd1", wr_data[base+1], 32'h00000001);
    chk("t6_wa1", wr_addr[base+1], 10'd1);
    chk("t6_done", done, 1'b1);
    chk("t6_error", error, 1'b0);

    // Whole-run write-strobe properties
    repeat (2) @(negedge clk);
    chk("ready_in_write", rdy_viol, 0);
    chk("write_one_cycle", dbl_write, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Write-side initiator for the instruction/data memory. Replaces the hard-coded program image with a program streamed in at boot.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. Drives the memory's write port (data, address, write strobe) one word at a time, then verifies a trailing XOR checksum.
- Holds the processor in reset until the image is loaded and verified.

Parameters:
- ADDR_W, 10, width of memory address bus
- DATA_W, 32, memory word width (fixed at 4 bytes; other values unsupported)
- MAX_WORDS, 128, memory depth; a header length above this is an error
- BASE_ADDR, 0, address of the first word written

Ports:
- clk  in  1  single system clock; all logic on rising edge; memory write clock is tied to clk
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a load session
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader accepts byte_in this cycle
- mem_dado  out  DATA_W  word to memory
- mem_endereco  out  ADDR_W  write address
- mem_write  out  1  write strobe, one cycle per word
- busy  out  1  session in progress
- done  out  1  image loaded and checksum OK (sticky)
- error  out  1  length or checksum failure (sticky)
- cpu_hold  out  1  processor reset/hold request

Behaviour:
- Reset values:
  - byte_ready=0, mem_write=0, mem_dado=0, mem_endereco=BASE_ADDR.
  - busy=0, done=0, error=0, cpu_hold=1.
  - State=IDLE; internal count, checksum and byte index cleared.
- rst mid-session aborts immediately. Words already written stay in memory; no further writes occur.
- A byte transfer happens on a rising edge where byte_valid=1 and byte_ready=1.
- Stream format: LEN_HI, LEN_LO (16-bit word count N), then N×4 data bytes (most significant byte first), then one checksum byte. The checksum is the XOR of all data bytes; length bytes are excluded.
- States:
  - IDLE: ready=0. On start: busy=1, done=0, error=0, cpu_hold=1, index/checksum cleared, address=BASE_ADDR; go to LEN_HI. byte_valid in IDLE is ignored.
  - LEN_HI: ready=1; on transfer, latch the high byte and go to LEN_LO.
  - LEN_LO: ready=1; on transfer, form N, then:
    - N=0 → CHK.
    - N>MAX_WORDS → ERR.
    - otherwise → COLLECT.
  - COLLECT: ready=1; shift the byte into the word register and XOR it into the checksum. On the 4th byte go to WRITE.
  - WRITE: ready=0. mem_write=1 for exactly one cycle with mem_dado and mem_endereco stable. Next cycle: mem_write=0, address+1, words_left−1. If words_left reaches 0 → CHK, else → COLLECT.
  - CHK: ready=1; on transfer compare the byte with the checksum. Match → DONE; mismatch → ERR.
  - DONE: busy=0, done=1, cpu_hold=0, ready=0. start re-enters a session (cpu_hold back to 1).
  - ERR: busy=0, error=1, cpu_hold=1, ready=0. Only start or rst leaves ERR.
- Latency: a 4th byte accepted on edge k drives mem_write=1 during cycle k+1. byte_ready returns to 1 in cycle k+2. Sustained throughput is 4 bytes per 5 cycles.
- Address arithmetic: ADDR_W bits, no wrap expected, since N≤MAX_WORDS is guaranteed by the length check. The last word written is at BASE_ADDR+N−1.
- start while busy is ignored.
- byte_valid may drop between bytes; the loader waits indefinitely with no timeout.
- mem_write is never asserted outside WRITE.

Test Plan:
- rst, start, stream 00 01 DE AD BE EF 22 → one write of 0xDEADBEEF at addr 0, then done=1, cpu_hold=0, error=0.
- N=3 with words 0x04001FCD, 0x5400001C, 0x48000000 and correct checksum → writes at addr 0,1,2 in order, each mem_write exactly one cycle; done=1.
- Header 00 81 (129 > 128) → error=1, no mem_write ever, cpu_hold=1, byte_ready=0 afterwards.
- N=1 word 0x11223344 with checksum 0x00 (correct value 0x44) → write occurs, then error=1, done=0, cpu_hold=1.
- byte_valid toggled 1/0 every cycle during N=2 load → identical writes and final state to the back-to-back case. byte_ready=0 in every WRITE cycle.
- rst asserted after the 2nd data byte of N=2 → next cycle all outputs at reset values, no write. Subsequent start plus a full stream loads correctly from BASE_ADDR.
